// File: rtl/lab_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lab_pkg
//  Description : Shared constants for the lab datapath counters/timers.
//  Revision    : 1.0  initial release
// ============================================================================
package lab_pkg;

    // Default counter / reload register width
    localparam int WIDTH = 12;

    // Timer state encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage : lab_pkg
`default_nettype wire

// File: rtl/reload_reg.sv
`default_nettype none
// ============================================================================
//  Module      : reload_reg
//  Description : Reload value register with a same-cycle bypass so that a
//                start coinciding with a load uses the freshly loaded value.
//  Revision    : 1.0  initial release
// ============================================================================
module reload_reg
    import lab_pkg::*;
#(
    parameter int WIDTH = lab_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] rld,
    output logic [WIDTH-1:0] eff
);

    logic [WIDTH-1:0] r_rld;

    // Capture the reload value whenever load is asserted, in any timer state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rld <= '0;
        end else if (load) begin
            r_rld <= ld_val;
        end
    end

    assign rld = r_rld;
    assign eff = load ? ld_val : r_rld;

endmodule : reload_reg
`default_nettype wire

// File: rtl/countdown_timer_12.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer_12
//  Description : Loadable down-counter/timer with one-shot or periodic
//                operation and a one-cycle done pulse at terminal count.
//  Revision    : 1.0  initial release
// ============================================================================
module countdown_timer_12
    import lab_pkg::*;
#(
    parameter int WIDTH = lab_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] val,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_zero = '0;

    logic [WIDTH-1:0] w_rld;
    logic [WIDTH-1:0] w_eff;
    logic [WIDTH-1:0] r_val;
    logic [0:0]       r_state;
    logic             r_done;

    reload_reg #(
        .WIDTH (WIDTH)
    ) u_reload_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .ld_val (ld_val),
        .rld    (w_rld),
        .eff    (w_eff)
    );

    // Countdown state machine: stop beats start, start beats counting
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_val   <= c_zero;
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (stop) begin
                r_val   <= c_zero;
                r_state <= ST_IDLE;
            end else if (start) begin
                if (w_eff == c_zero) begin
                    // Zero-length timer expires immediately
                    r_val   <= c_zero;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end else begin
                    r_val   <= w_eff;
                    r_state <= ST_RUN;
                end
            end else if ((r_state == ST_RUN) && en) begin
                if (r_val > c_one) begin
                    r_val <= r_val - c_one;
                end else if (r_val == c_one) begin
                    r_done <= 1'b1;
                    // Periodic mode reloads from the registered value; a zero
                    // reload value cannot sustain a period so the timer parks
                    if (auto_reload && (w_rld != c_zero)) begin
                        r_val <= w_rld;
                    end else begin
                        r_val   <= c_zero;
                        r_state <= ST_IDLE;
                    end
                end else begin
                    // Count of zero while running is unreachable; park safely
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    assign val  = r_val;
    assign busy = (r_state == ST_RUN);
    assign done = r_done;

endmodule : countdown_timer_12
`default_nettype wire

// File: tb/tb_countdown_timer_12.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer_12
//  Description : Self-checking bench for countdown_timer_12 with a
//                behavioural timer model and randomized stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_countdown_timer_12;

    localparam int W = 12;

    logic         clk;
    logic         rst;
    logic         en;
    logic         load;
    logic [W-1:0] ld_val;
    logic         start;
    logic         stop;
    logic         auto_reload;
    logic [W-1:0] val;
    logic         busy;
    logic         done;

    int passed = 0;
    int total  = 0;

    // Behavioural model: remaining ticks, running flag, reload value, pulse
    int m_rld;
    int m_val;
    bit m_run;
    bit m_done;

    countdown_timer_12 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .ld_val      (ld_val),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .val         (val),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one clock using the timer's documented rules
    task automatic model_edge();
        int eff;
        int next_rld;
        if (!rst) begin
            m_rld = 0; m_val = 0; m_run = 0; m_done = 0;
            return;
        end
        m_done   = 0;
        eff      = load ? int'(ld_val) : m_rld;
        next_rld = eff;
        if (stop) begin
            m_val = 0; m_run = 0;
        end else if (start) begin
            if (eff == 0) begin
                m_val = 0; m_done = 1; m_run = 0;
            end else begin
                m_val = eff; m_run = 1;
            end
        end else if (m_run && en) begin
            if (m_val == 1) begin
                m_done = 1;
                if (auto_reload && m_rld != 0) m_val = m_rld;
                else begin
                    m_val = 0; m_run = 0;
                end
            end else begin
                m_val = m_val - 1;
            end
        end
        m_rld = next_rld;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b1; en = 1'b0; load = 1'b0; ld_val = '0;
        start = 1'b0; stop = 1'b0; auto_reload = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        load = 1'b1; ld_val = 12'd10; start = 1'b1; en = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        repeat (3) tick();
        total++;
        if (val !== 12'd7) $display("FAIL reset_precount val=%0d expected=7", val);
        else passed++;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        total++;
        if ({val, busy, done} !== {12'd0, 1'b0, 1'b0})
            $display("FAIL reset_mid val=%0d busy=%0b done=%0b expected 0/0/0", val, busy, done);
        else passed++;
        // Reload register cleared: a plain start acts as a zero-length timer
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if ({val, busy, done} !== {12'd0, 1'b0, 1'b1})
            $display("FAIL reset_rld val=%0d busy=%0b done=%0b expected 0/0/1", val, busy, done);
        else passed++;
        tick();
    endtask

    task automatic test_oneshot();
        int exp_v[6] = '{5, 4, 3, 2, 1, 0};
        idle_inputs();
        load = 1'b1; ld_val = 12'd5;
        tick();
        load = 1'b0; start = 1'b1; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            start = 1'b0;
            total++;
            if ({val, busy, done} !== {12'(exp_v[i]), (i < 5), (i == 5)})
                $display("FAIL oneshot[%0d] val=%0d busy=%0b done=%0b expected %0d/%0b/%0b",
                         i, val, busy, done, exp_v[i], (i < 5), (i == 5));
            else passed++;
        end
        tick();
        total++;
        if (done !== 1'b0) $display("FAIL oneshot_pulse done=%0b expected=0", done);
        else passed++;
    endtask

    task automatic test_pause();
        bit pat[6]   = '{1, 0, 0, 1, 1, 1};
        int exp_v[6] = '{3, 3, 3, 2, 1, 0};
        idle_inputs();
        load = 1'b1; ld_val = 12'd4; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        total++;
        if (val !== 12'd4) $display("FAIL pause_start val=%0d expected=4", val);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            en = pat[i];
            tick();
            total++;
            if ({val, done} !== {12'(exp_v[i]), (i == 5)})
                $display("FAIL pause[%0d] val=%0d done=%0b expected %0d/%0b",
                         i, val, done, exp_v[i], (i == 5));
            else passed++;
        end
    endtask

    task automatic test_periodic();
        int exp_v[10] = '{2, 1, 3, 2, 1, 3, 2, 1, 3, 2};
        idle_inputs();
        load = 1'b1; ld_val = 12'd3; auto_reload = 1'b1; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0; en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({val, busy, done} !== {12'(exp_v[i]), 1'b1, ((i % 3) == 2)})
                $display("FAIL periodic[%0d] val=%0d busy=%0b done=%0b expected %0d/1/%0b",
                         i, val, busy, done, exp_v[i], ((i % 3) == 2));
            else passed++;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_load_start();
        idle_inputs();
        load = 1'b1; ld_val = 12'd2;
        tick();
        ld_val = 12'h7FF; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        total++;
        if ({val, busy} !== {12'h7FF, 1'b1})
            $display("FAIL load_start_bypass val=%0h busy=%0b expected 7ff/1", val, busy);
        else passed++;
        stop = 1'b1;
        tick();
        stop = 1'b0; load = 1'b1; ld_val = 12'd0; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        total++;
        if ({val, busy, done} !== {12'd0, 1'b0, 1'b1})
            $display("FAIL load_start_zero val=%0d busy=%0b done=%0b expected 0/0/1", val, busy, done);
        else passed++;
        en = 1'b1;
        tick();
        total++;
        if ({val, busy, done} !== {12'd0, 1'b0, 1'b0})
            $display("FAIL zero_stays_idle val=%0d busy=%0b done=%0b expected 0/0/0", val, busy, done);
        else passed++;
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        load = 1'b1; ld_val = 12'd6; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        total++;
        if ({val, busy, done} !== {12'd0, 1'b0, 1'b0})
            $display("FAIL stop_vs_start val=%0d busy=%0b done=%0b expected 0/0/0", val, busy, done);
        else passed++;
        load = 1'b1; ld_val = 12'd2; start = 1'b1;
        tick();
        start = 1'b0; ld_val = 12'd9;
        tick();
        load = 1'b0;
        total++;
        if ({val, busy} !== {12'd2, 1'b1})
            $display("FAIL load_during_run val=%0d busy=%0b expected 2/1", val, busy);
        else passed++;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if ({val, busy, done} !== {12'd9, 1'b1, 1'b0})
            $display("FAIL restart val=%0d busy=%0b done=%0b expected 9/1/0", val, busy, done);
        else passed++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_random();
        int errs = 0;
        idle_inputs();
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 99) != 0);
            en          = ($urandom_range(0, 3) != 0);
            load        = ($urandom_range(0, 9) == 0);
            ld_val      = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
            start       = ($urandom_range(0, 14) == 0);
            stop        = ($urandom_range(0, 39) == 0);
            auto_reload = ($urandom_range(0, 1) == 1);
            tick();
            total++;
            if ({val, busy, done} !== {W'(m_val), m_run, m_done}) begin
                if (errs < 10)
                    $display("FAIL random[%0d] val=%0d busy=%0b done=%0b expected %0d/%0b/%0b",
                             i, val, busy, done, m_val, m_run, m_done);
                errs++;
            end else passed++;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        tick();
        total++;
        if ({val, busy, done} !== {12'd0, 1'b0, 1'b0})
            $display("FAIL reset_init val=%0d busy=%0b done=%0b expected 0/0/0", val, busy, done);
        else passed++;
        test_reset();
        test_oneshot();
        test_pause();
        test_periodic();
        test_load_start();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_countdown_timer_12
`default_nettype wire

// File: doc/countdown_timer_12.md
Name: countdown_timer_12

Overview:
- Loadable 12-bit down-counter/timer, the count-down complement of the team's 12-bit up-counter with enable and load.
- Software or an upstream FSM loads a reload value, pulses start, and the block decrements on each enabled clock.
- It raises a one-cycle done pulse at terminal count, then either stops or auto-reloads for periodic ticks.
- Sits beside the up-counter in the lab datapath as the timing/pacing source for ROM-address sweeps and display refresh.

Parameters:
- WIDTH, 12, counter and reload register width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
- en  input  1  count enable; low pauses the countdown while in RUN
- load  input  1  capture ld_val into the reload register this cycle
- ld_val  input  WIDTH  reload value bus
- start  input  1  begin (or restart) a countdown from the reload register
- stop  input  1  abort countdown, return to IDLE
- auto_reload  input  1  1 = periodic mode, 0 = one-shot
- val  output  WIDTH  current count
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when countdown reaches terminal count

Behaviour:
- Registers: rld[WIDTH-1:0], val, state {IDLE, RUN}, done.
- Reset (rst==0 at edge): rld=0, val=0, state=IDLE, busy=0, done=0. Reset overrides all other inputs, including mid-count.
- done is registered and defaults to 0 every cycle unless set below. busy = (state==RUN), combinational from state.
- load: rld<=ld_val in any state. It does not alter val or state.
- Effective reload value eff = load ? ld_val : rld, so a start in the same cycle as load uses the new value.
- Priority within a cycle, after reset: stop > start > count.
- stop (any state): val<=0, state<=IDLE, no done pulse.
- start (IDLE or RUN; RUN means restart):
  - if eff==0: val<=0, done<=1, state<=IDLE (zero-length timer);
  - else: val<=eff, state<=RUN.
- RUN with en==0: val and state hold (pause). No done.
- RUN with en==1 and val>1: val<=val-1.
- RUN with en==1 and val==1 (terminal): done<=1.
  - auto_reload==1: val<=rld, state stays RUN. If rld==0 at that moment: val<=0, state<=IDLE.
  - auto_reload==0: val<=0, state<=IDLE.
- Latency:
  - start registered at edge N gives val=eff visible after N.
  - With en held high, done is high in the cycle following the edge where val decremented from 1.
  - One-shot with value L gives done exactly L enabled edges after start.
  - Periodic period = rld enabled cycles.
- IDLE with en==1 and no start: no counting; val holds. No wrap-around ever: val never decrements below 0.
- auto_reload is sampled only at terminal count. Changing it mid-count is legal.
- load during RUN changes only the next reload/start value; the current count is unaffected.

Decomposition:
- Shared package lab_pkg: WIDTH default constant (12); state encoding constants ST_IDLE=1'b0, ST_RUN=1'b1.
- Optional sub-module reload_reg (rld register plus eff bypass mux). Otherwise a single module; no further hierarchy needed.

Test Plan:
- Reset mid-count: load 10, start, 3 enabled cycles (val=7), rst=0 for one edge -> val=0, busy=0, done=0, rld=0.
- One-shot: load 5, start, en=1 -> val 5,4,3,2,1,0; done high exactly one cycle when val becomes 0; busy falls the same cycle.
- Pause: load 4, start, en toggled 1,0,0,1,1,1 -> val 4,3,3,3,2,1,0; done only after the third enabled decrement following the pause.
- Periodic: load 3, auto_reload=1, start, en=1 for 10 cycles -> val 3,2,1,3,2,1,3,...; done pulses every 3 cycles; busy stays 1.
- Simultaneous load+start with ld_val=0x7FF while rld=2 -> val=0x7FF next cycle. load+start with ld_val=0 -> done pulse, val=0, stays IDLE.
- Stop vs start same cycle during RUN (val=6) -> val=0, IDLE, no done. Restart during RUN at val=2 with rld=9 -> val=9, no done.
